// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the VGA timing generator.
package vga_pkg;

    // 640x480 @ 60 Hz, counted in pixels and lines
    localparam int VGA640_H_DISP  = 640;
    localparam int VGA640_H_FP    = 16;
    localparam int VGA640_H_SYNC  = 96;
    localparam int VGA640_H_BP    = 48;
    localparam int VGA640_V_DISP  = 480;
    localparam int VGA640_V_FP    = 10;
    localparam int VGA640_V_SYNC  = 2;
    localparam int VGA640_V_BP    = 29;

    // 800x600 @ 60 Hz, kept here for a later mode switch
    localparam int SVGA800_H_DISP = 800;
    localparam int SVGA800_H_FP   = 40;
    localparam int SVGA800_H_SYNC = 128;
    localparam int SVGA800_H_BP   = 88;
    localparam int SVGA800_V_DISP = 600;
    localparam int SVGA800_V_FP   = 1;
    localparam int SVGA800_V_SYNC = 4;
    localparam int SVGA800_V_BP   = 23;

    // Bundle of the timing signals that travel through the delay line
    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic de;
    } timing_t;

    function automatic int h_total(input int disp, input int fp, input int sync, input int bp);
        return disp + fp + sync + bp;
    endfunction

    function automatic int v_total(input int disp, input int fp, input int sync, input int bp);
        return disp + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Output bundle of the VGA timing generator.
// There is no handshake: pix_en is a one-cycle strobe that marks the last
// system clock of each pixel period; every other signal is a level that is
// valid on every clock, and line_start/frame_start are one-clock pulses
// that coincide with pix_en. Consumers never back-pressure the generator.
interface vga_timing_gen_if #(
    parameter int COUNTER_BITS = 10
);
    logic                    pix_en;
    logic [COUNTER_BITS-1:0] h_count;
    logic [COUNTER_BITS-1:0] v_count;
    logic                    h_sync;
    logic                    v_sync;
    logic                    de;
    logic                    line_start;
    logic                    frame_start;

    modport master (
        output pix_en, h_count, v_count, h_sync, v_sync, de, line_start, frame_start
    );

    modport slave (
        input pix_en, h_count, v_count, h_sync, v_sync, de, line_start, frame_start
    );
endinterface

// File: rtl/vga_delay_line.sv
// Pixel-rate delay line: DEPTH stages that advance on shift_en_i, followed by
// an output register that samples every clock. With DEPTH=0 it is a plain
// registered copy of d_i.
module vga_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             clear_ni,
    input  logic             shift_en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] tail;
    logic [WIDTH-1:0] out_q;

    if (DEPTH > 0) begin : g_stages
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Shift register advancing once per pixel period
        always_ff @(posedge clk_i) begin
            if (!clear_ni) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
            end else if (shift_en_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign tail = stage_q[DEPTH-1];
    end else begin : g_bypass
        logic unused_shift_en;
        assign unused_shift_en = shift_en_i;
        assign tail            = d_i;
    end

    // Output register so the timing outputs are always glitch-free flops
    always_ff @(posedge clk_i) begin
        if (!clear_ni) out_q <= RST_VAL;
        else           out_q <= tail;
    end

    assign q_o = out_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator running in the system clock domain.
// A clock divider produces a pixel-enable strobe; h/v counters advance on it
// and the decoded sync/DE go through a delay line matching the fetch pipe.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int COUNTER_BITS = 10,
    parameter int H_DISP       = VGA640_H_DISP,
    parameter int H_FP         = VGA640_H_FP,
    parameter int H_SYNC       = VGA640_H_SYNC,
    parameter int H_BP         = VGA640_H_BP,
    parameter int V_DISP       = VGA640_V_DISP,
    parameter int V_FP         = VGA640_V_FP,
    parameter int V_SYNC       = VGA640_V_SYNC,
    parameter int V_BP         = VGA640_V_BP,
    parameter bit H_SYNC_POL   = 1'b0,
    parameter bit V_SYNC_POL   = 1'b0,
    parameter int CLK_DIV      = 2,
    parameter int PIPE_DELAY   = 0
) (
    input  logic                    clk_50MHz,
    input  logic                    clear,
    vga_timing_gen_if.master        vga
);

    localparam int H_TOTAL = h_total(H_DISP, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_DISP, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW      = COUNTER_BITS + 1;

    // Build-time sanity: counters must hold every count, divider must be non-zero
    if (H_TOTAL > 2**COUNTER_BITS) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL does not fit in COUNTER_BITS");
    end
    if (V_TOTAL > 2**COUNTER_BITS) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL does not fit in COUNTER_BITS");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_pipe
        $error("vga_timing_gen: PIPE_DELAY must be within 0..7");
    end

    localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COUNTER_BITS-1:0] H_LAST   = COUNTER_BITS'(H_TOTAL - 1);
    localparam logic [COUNTER_BITS-1:0] V_LAST   = COUNTER_BITS'(V_TOTAL - 1);

    // Decode bounds are one bit wider so a boundary equal to 2^COUNTER_BITS still compares
    localparam logic [CW-1:0] H_DE_END   = CW'(H_DISP);
    localparam logic [CW-1:0] H_SY_START = CW'(H_DISP + H_FP);
    localparam logic [CW-1:0] H_SY_END   = CW'(H_DISP + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_DE_END   = CW'(V_DISP);
    localparam logic [CW-1:0] V_SY_START = CW'(V_DISP + V_FP);
    localparam logic [CW-1:0] V_SY_END   = CW'(V_DISP + V_FP + V_SYNC);

    localparam timing_t TIMING_IDLE = '{h_sync: ~H_SYNC_POL, v_sync: ~V_SYNC_POL, de: 1'b0};

    logic [DIV_W-1:0]        div_q, div_d;
    logic                    pix_en_q, pix_en_d;
    logic [COUNTER_BITS-1:0] h_q, h_d;
    logic [COUNTER_BITS-1:0] v_q, v_d;
    logic                    line_start_q, line_start_d;
    logic                    frame_start_q, frame_start_d;

    logic [CW-1:0] h_ext, v_ext;
    logic          hs_act, vs_act;
    timing_t       timing_raw, timing_dly;

    // Next-state for divider, counters and the start pulses
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pix_en_d = (div_q == DIV_LAST);
        h_d      = h_q;
        v_d      = v_q;
        if (pix_en_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        // Pulses land in the same cycle as pix_en with the counters they describe
        line_start_d  = pix_en_d && (h_d == '0);
        frame_start_d = line_start_d && (v_d == '0);
    end

    // Divider, counters and start pulses; all registered
    always_ff @(posedge clk_50MHz) begin
        if (!clear) begin
            div_q         <= '0;
            pix_en_q      <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_en_q      <= pix_en_d;
            h_q           <= h_d;
            v_q           <= v_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Raw timing decoded from the undelayed counters
    always_comb begin
        h_ext             = {1'b0, h_q};
        v_ext             = {1'b0, v_q};
        hs_act            = (h_ext >= H_SY_START) && (h_ext < H_SY_END);
        vs_act            = (v_ext >= V_SY_START) && (v_ext < V_SY_END);
        timing_raw.de     = (h_ext < H_DE_END) && (v_ext < V_DE_END);
        timing_raw.h_sync = hs_act ? H_SYNC_POL : ~H_SYNC_POL;
        timing_raw.v_sync = vs_act ? V_SYNC_POL : ~V_SYNC_POL;
    end

    vga_delay_line #(
        .WIDTH   ($bits(timing_t)),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (TIMING_IDLE)
    ) u_delay (
        .clk_i      (clk_50MHz),
        .clear_ni   (clear),
        .shift_en_i (pix_en_q),
        .d_i        (timing_raw),
        .q_o        (timing_dly)
    );

    assign vga.pix_en      = pix_en_q;
    assign vga.h_count     = h_q;
    assign vga.v_count     = v_q;
    assign vga.h_sync      = timing_dly.h_sync;
    assign vga.v_sync      = timing_dly.v_sync;
    assign vga.de          = timing_dly.de;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four configurations run off one clock and clear,
// each compared every cycle with a model that derives outputs from the number
// of clocks since reset release.
module tb_vga_timing_gen;

    typedef struct {
        int d, p;
        int hd, hf, hs, hb;
        int vd, vf, vs, vb;
        bit hpol, vpol;
    } cfg_t;

    typedef struct {
        bit pix;
        int h, v;
        bit hs, vs, de, ls, fs;
    } exp_t;

    logic clk   = 1'b0;
    logic clear = 1'b0;
    int   t      = 0;
    int   errors = 0;
    int   checks = 0;

    cfg_t cfg_a, cfg_b, cfg_c, cfg_d;

    // line / frame trackers
    int a_last = -1, a_hs = 0;
    int d_last = -1, d_ls = 0, d_vs = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.COUNTER_BITS(10)) bus_a ();
    vga_timing_gen_if #(.COUNTER_BITS(10)) bus_b ();
    vga_timing_gen_if #(.COUNTER_BITS(4))  bus_c ();
    vga_timing_gen_if #(.COUNTER_BITS(5))  bus_d ();

    vga_timing_gen dut_a (.clk_50MHz(clk), .clear(clear), .vga(bus_a));

    vga_timing_gen #(.PIPE_DELAY(2)) dut_b (.clk_50MHz(clk), .clear(clear), .vga(bus_b));

    vga_timing_gen #(
        .COUNTER_BITS(4), .H_DISP(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CLK_DIV(1), .PIPE_DELAY(0)
    ) dut_c (.clk_50MHz(clk), .clear(clear), .vga(bus_c));

    vga_timing_gen #(
        .COUNTER_BITS(5), .H_DISP(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1), .CLK_DIV(3), .PIPE_DELAY(3)
    ) dut_d (.clk_50MHz(clk), .clear(clear), .vga(bus_d));

    // Expected outputs after t clock edges with clear high (t=0: reset edge).
    // Pixel index n counts completed pixel periods; sync/DE show pixel n-P of
    // the previous clock, or idle levels while fewer than P pixels have passed.
    function automatic exp_t model(input cfg_t c, input int tt);
        exp_t e;
        int ht, vt, n, m, p, h, v;
        ht    = c.hd + c.hf + c.hs + c.hb;
        vt    = c.vd + c.vf + c.vs + c.vb;
        n     = (tt >= 1) ? (tt - 1) / c.d : 0;
        e.pix = (tt >= 1) && (tt % c.d == 0);
        e.h   = n % ht;
        e.v   = (n / ht) % vt;
        e.ls  = e.pix && (e.h == 0);
        e.fs  = e.ls && (e.v == 0);
        m     = (tt >= 2) ? (tt - 2) / c.d : 0;
        if (tt >= 1 && m >= c.p) begin
            p    = m - c.p;
            h    = p % ht;
            v    = (p / ht) % vt;
            e.de = (h < c.hd) && (v < c.vd);
            e.hs = (h >= c.hd + c.hf && h < c.hd + c.hf + c.hs) ? c.hpol : !c.hpol;
            e.vs = (v >= c.vd + c.vf && v < c.vd + c.vf + c.vs) ? c.vpol : !c.vpol;
        end else begin
            e.de = 1'b0;
            e.hs = !c.hpol;
            e.vs = !c.vpol;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d: got %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic check_dut(input string name, input cfg_t c,
                             input logic pix, input logic [31:0] h, input logic [31:0] v,
                             input logic hs, input logic vs, input logic de,
                             input logic ls, input logic fs);
        exp_t e;
        e = model(c, t);
        check({name, ".pix_en"},      32'(pix), 32'(e.pix));
        check({name, ".h_count"},     h,        32'(e.h));
        check({name, ".v_count"},     v,        32'(e.v));
        check({name, ".h_sync"},      32'(hs),  32'(e.hs));
        check({name, ".v_sync"},      32'(vs),  32'(e.vs));
        check({name, ".de"},          32'(de),  32'(e.de));
        check({name, ".line_start"},  32'(ls),  32'(e.ls));
        check({name, ".frame_start"}, 32'(fs),  32'(e.fs));
    endtask

    // One clock: advance the release counter on the edge, check on the falling edge
    task automatic step();
        @(posedge clk);
        if (!clear) t = 0;
        else        t++;
        @(negedge clk);
        check_dut("a", cfg_a, bus_a.pix_en, 32'(bus_a.h_count), 32'(bus_a.v_count),
                  bus_a.h_sync, bus_a.v_sync, bus_a.de, bus_a.line_start, bus_a.frame_start);
        check_dut("b", cfg_b, bus_b.pix_en, 32'(bus_b.h_count), 32'(bus_b.v_count),
                  bus_b.h_sync, bus_b.v_sync, bus_b.de, bus_b.line_start, bus_b.frame_start);
        check_dut("c", cfg_c, bus_c.pix_en, 32'(bus_c.h_count), 32'(bus_c.v_count),
                  bus_c.h_sync, bus_c.v_sync, bus_c.de, bus_c.line_start, bus_c.frame_start);
        check_dut("d", cfg_d, bus_d.pix_en, 32'(bus_d.h_count), 32'(bus_d.v_count),
                  bus_d.h_sync, bus_d.v_sync, bus_d.de, bus_d.line_start, bus_d.frame_start);

        // 640x480 line: 800 pixels * 2 clocks, h_sync low for 96 pixels
        if (t == 0) begin
            a_last = -1;
            a_hs   = 0;
        end else begin
            if (bus_a.h_sync === 1'b0) a_hs++;
            if (bus_a.line_start === 1'b1) begin
                if (a_last >= 0) begin
                    check("a.line_period", 32'(t - a_last), 32'd1600);
                    check("a.hsync_clks",  32'(a_hs),       32'd192);
                end
                a_last = t;
                a_hs   = 0;
            end
        end

        // small frame: 17 pixels * 11 lines * 3 clocks, v_sync high for 2 lines
        if (t == 0) begin
            d_last = -1;
            d_ls   = 0;
            d_vs   = 0;
        end else begin
            if (bus_d.line_start === 1'b1) d_ls++;
            if (bus_d.v_sync === 1'b1)     d_vs++;
            if (bus_d.frame_start === 1'b1) begin
                if (d_last >= 0) begin
                    check("d.frame_period", 32'(t - d_last), 32'd561);
                    check("d.lines",        32'(d_ls),       32'd11);
                    check("d.vsync_clks",   32'(d_vs),       32'd102);
                end
                d_last = t;
                d_ls   = 0;
                d_vs   = 0;
            end
        end
    endtask

    initial begin
        cfg_a = '{d: 2, p: 0, hd: 640, hf: 16, hs: 96, hb: 48,
                  vd: 480, vf: 10, vs: 2, vb: 29, hpol: 1'b0, vpol: 1'b0};
        cfg_b = cfg_a;
        cfg_b.p = 2;
        cfg_c = '{d: 1, p: 0, hd: 8, hf: 1, hs: 2, hb: 1,
                  vd: 4, vf: 1, vs: 1, vb: 1, hpol: 1'b1, vpol: 1'b0};
        cfg_d = '{d: 3, p: 3, hd: 10, hf: 2, hs: 3, hb: 2,
                  vd: 6, vf: 1, vs: 2, vb: 2, hpol: 1'b0, vpol: 1'b1};

        // reset held for a few clocks, then release and run past two full lines
        clear = 1'b0;
        repeat (3) step();
        clear = 1'b1;
        repeat (4000) step();

        // random run lengths interrupted by short mid-frame resets
        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(30, 1700)) step();
            clear = 1'b0;
            repeat ($urandom_range(1, 3)) step();
            clear = 1'b1;
        end

        // uninterrupted tail after the last reset
        repeat (3500) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator; successor to the fixed 640x480 controller in the display path. Runs on the system clock and produces a one-cycle pixel-enable strobe instead of a derived clock, so all timing logic stays in a single clock domain. Fully parametrised porches, sync widths and sync polarities. Includes a configurable sync/DE delay line so the timing outputs line up with pixel data from a fetch pipeline that is PIPE_DELAY pixels deep.

Parameters:
H_DISP, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_DISP, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 29, vertical back porch (lines)
H_SYNC_POL, 0, active level of h_sync (0 = active-low)
V_SYNC_POL, 0, active level of v_sync (0 = active-low)
CLK_DIV, 2, system clocks per pixel (must be >= 1)
PIPE_DELAY, 0, pixel periods of delay applied to h_sync, v_sync and de (0..7)
COUNTER_BITS, 10, width of the h_count and v_count outputs

Ports:
clk_50MHz  in  1  system clock
clear  in  1  synchronous active-low reset
pix_en  out  1  one-clock strobe, high on the last system cycle of each pixel period
h_count  out  COUNTER_BITS  current pixel column, 0..H_TOTAL-1, undelayed (used as fetch address)
v_count  out  COUNTER_BITS  current line, 0..V_TOTAL-1, undelayed
h_sync  out  1  horizontal sync, delayed by PIPE_DELAY
v_sync  out  1  vertical sync, delayed by PIPE_DELAY
de  out  1  data enable (visible area), delayed by PIPE_DELAY
line_start  out  1  one-clock pulse, coincides with pix_en while h_count==0
frame_start  out  1  one-clock pulse, coincides with pix_en while h_count==0 and v_count==0

Behaviour:
- Totals: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (521).
- Elaboration check: the build fails if H_TOTAL or V_TOTAL exceeds 2^COUNTER_BITS, or if CLK_DIV is 0.
- Reset: clear==0 is sampled on the clk_50MHz edge. On reset:
  - divider, h_count and v_count go to 0;
  - pix_en, de, line_start and frame_start go to 0;
  - h_sync goes to ~H_SYNC_POL and v_sync to ~V_SYNC_POL;
  - all delay-line stages load their inactive values.
  Reset mid-frame behaves identically; there is no partial state.
- Divider: counts 0..CLK_DIV-1 and wraps. pix_en = (div==CLK_DIV-1), registered.
  - The first pix_en occurs on the CLK_DIV-th clock after clear rises.
  - With CLK_DIV=1, pix_en is high on every clock from the first clock after reset.
- Counters advance only on the clock edge at which pix_en is high:
  - h_count wraps H_TOTAL-1 -> 0, otherwise increments.
  - On the h wrap, v_count wraps V_TOTAL-1 -> 0, otherwise increments.
  - Both counts are registered and glitch-free. No count ever equals a total.
- Raw timing, decoded from the counters:
  - de_raw = h_count<H_DISP && v_count<V_DISP.
  - hs_act = H_DISP+H_FP <= h_count < H_DISP+H_FP+H_SYNC.
  - vs_act = V_DISP+V_FP <= v_count < V_DISP+V_FP+V_SYNC.
  - h_sync = hs_act ? H_SYNC_POL : ~H_SYNC_POL; v_sync is formed the same way.
  - v_sync changes at h_count==0 of the line boundary, aligned with the hsync frame.
- Delay line:
  - PIPE_DELAY=0: outputs are a registered copy of raw timing, so they change on the clock after the counter changes.
  - PIPE_DELAY=N: each additional stage shifts only on pix_en, giving N further pixel periods of delay.
  - h_count and v_count are never delayed.
- line_start and frame_start are registered, high for exactly one clk_50MHz cycle, and not delayed.

Decomposition:
- Package vga_pkg holds:
  - the 640x480@60 timing constants (H_DISP..V_BP) as defaults, plus 800x600 constants for future use;
  - functions h_total() and v_total().
- One sub-module, vga_delay_line, parametrised by WIDTH and DEPTH:
  - takes a shift enable;
  - applies a reset value on clear;
  - instantiated once with WIDTH=3 for {h_sync, v_sync, de}.

Test Plan:
- Reset release with defaults -> first pix_en on clock 2; h_count=0 and v_count=0; h_sync=v_sync=1; de=1 one clock after the counters settle (pixel 0,0 is visible); frame_start pulses on that first pix_en.
- Free-run one line -> h_count goes 798, 799, 0 and v_count increments on the wrap; h_sync is low exactly for h_count 656..751 (96 pixels = 192 clocks); de is low for h_count 640..799; line_start appears once per 1600 clocks.
- Free-run one frame -> v_count wraps 520 -> 0; v_sync is low for lines 490..491 only; frame_start period is exactly 800*521*2 = 833600 clocks; line_start fires 521 times per frame.
- PIPE_DELAY=2 versus PIPE_DELAY=0 run side by side -> h_sync, v_sync and de edges shift by exactly 4 clocks; h_count and v_count are identical in both.
- CLK_DIV=1, H_SYNC_POL=1, small timing (H 8/1/2/1, V 4/1/1/1) -> pix_en constantly high; h_sync is high for h_count 9..10; H_TOTAL=12 and V_TOTAL=7 wraps are checked.
- clear driven low mid-frame at h=300, v=200 for one clock -> on the next clock all outputs hold reset values; the timing sequence then restarts identically to the first test.
